mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// Memory arbiter: shares one memory port between fetch and data requesters.
// Data has fixed priority; a watchdog and misalignment check trap into a sticky error.
module mem_arb #(
  parameter int unsigned WDOG = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic        halt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StBusyIf,
    StBusyDm,
    StHalted,
    StErr
  } state_e;

  // Counter value in the last permitted busy cycle.
  localparam logic [3:0] WdogLast = 4'(WDOG - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        mem_en_q, mem_en_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StHalted;
        end else if (dm_req) begin
          if (dm_addr[0]) begin
            state_d = StErr;
          end else begin
            state_d  = StBusyDm;
            wr_d     = dm_wr;
            addr_d   = dm_addr;
            wdata_d  = dm_wdata;
            cnt_d    = 4'd0;
            mem_en_d = 1'b1;
          end
        end else if (if_req) begin
          state_d  = StBusyIf;
          wr_d     = 1'b0;
          addr_d   = if_addr;
          cnt_d    = 4'd0;
          mem_en_d = 1'b1;
        end
      end
      StBusyIf, StBusyDm: begin
        if (mem_done) begin
          state_d = halt ? StHalted : StIdle;
        end else if (cnt_q == WdogLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = state_q;
    endcase
    halted_d = (state_d == StHalted);
    err_d    = (state_d == StErr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      mem_en_q <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_en_q <= mem_en_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    mem_en    = mem_en_q;
    mem_wr    = wr_q & (state_q == StBusyDm);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_done   = mem_done & (state_q == StBusyIf);
    dm_done   = mem_done & (state_q == StBusyDm);
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
    if_stall  = if_req & ~if_done;
    dm_stall  = dm_req & ~dm_done;
    halted    = halted_q;
    err       = err_q;
  end

endmodule
